// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks every post-EX result in a DEPTH-deep shift register,
// resolves EX operands to the youngest in-flight value and drives RF write-back.
module fwd_scoreboard #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int NUM_SRC     = 2,
  parameter int DEPTH       = 2,
  parameter int LOAD_STAGE  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ex_valid,
  input  logic                           ex_regwrite,
  input  logic                           ex_is_load,
  input  logic [RFIDX_WIDTH-1:0]         ex_rd,
  input  logic [XLEN-1:0]                ex_result,
  input  logic [NUM_SRC*RFIDX_WIDTH-1:0] ex_src_idx,
  input  logic [NUM_SRC-1:0]             ex_src_use,
  input  logic [NUM_SRC*XLEN-1:0]        rf_rdata,
  input  logic                           flush,
  input  logic                           ld_valid,
  input  logic [XLEN-1:0]                ld_data,
  output logic [NUM_SRC*XLEN-1:0]        fwd_data,
  output logic                           stall,
  output logic                           wb_we,
  output logic [RFIDX_WIDTH-1:0]         wb_rd,
  output logic [XLEN-1:0]                wb_data,
  output logic                           ld_err
);

  localparam int WB_IDX = DEPTH - 1;

  logic                   v_q    [DEPTH];
  logic                   rw_q   [DEPTH];
  logic                   ld_q   [DEPTH];
  logic                   rdy_q  [DEPTH];
  logic [RFIDX_WIDTH-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]        data_q [DEPTH];

  logic                   v_d    [DEPTH];
  logic                   rw_d   [DEPTH];
  logic                   ld_d   [DEPTH];
  logic                   rdy_d  [DEPTH];
  logic [RFIDX_WIDTH-1:0] rd_d   [DEPTH];
  logic [XLEN-1:0]        data_d [DEPTH];

  logic                   ld_err_q;
  logic                   ld_err_d;
  logic                   ld_pend;
  logic                   ld_fill;
  logic                   wb_byp;
  logic [NUM_SRC-1:0]     src_wait;

  // A load is outstanding only while it sits un-filled at the return stage.
  assign ld_pend = v_q[LOAD_STAGE] && ld_q[LOAD_STAGE] && !rdy_q[LOAD_STAGE];
  assign ld_fill = ld_valid && ld_pend;

  // Operand resolution: walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_data = rf_rdata;
    src_wait = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (v_q[i] && rw_q[i] && (rd_q[i] != '0) &&
            (rd_q[i] == ex_src_idx[k*RFIDX_WIDTH +: RFIDX_WIDTH])) begin
          if (rdy_q[i]) begin
            fwd_data[k*XLEN +: XLEN] = data_q[i];
            src_wait[k]              = 1'b0;
          end else if ((i == LOAD_STAGE) && ld_q[i] && ld_valid) begin
            fwd_data[k*XLEN +: XLEN] = ld_data;
            src_wait[k]              = 1'b0;
          end else begin
            fwd_data[k*XLEN +: XLEN] = data_q[i];
            src_wait[k]              = 1'b1;
          end
        end
      end
    end
  end

  assign stall = ex_valid && |(src_wait & ex_src_use);

  // Next-state: shift every entry one stage, inserting EX or a bubble at the head.
  always_comb begin
    v_d[0]    = ex_valid && !stall && !flush;
    rw_d[0]   = ex_regwrite;
    ld_d[0]   = ex_is_load;
    rdy_d[0]  = !ex_is_load;
    rd_d[0]   = ex_rd;
    data_d[0] = ex_result;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]  = v_q[i-1];
      rw_d[i] = rw_q[i-1];
      ld_d[i] = ld_q[i-1];
      rd_d[i] = rd_q[i-1];
      if ((i == LOAD_STAGE + 1) && ld_fill) begin
        rdy_d[i]  = 1'b1;
        data_d[i] = ld_data;
      end else begin
        rdy_d[i]  = rdy_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
    ld_err_d = ld_valid && !ld_pend;
  end

  // Stage registers: only the valid bits and the error pulse see reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i] <= 1'b0;
      end
      ld_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i] <= v_d[i];
      end
      ld_err_q <= ld_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rw_q[i]   <= rw_d[i];
      ld_q[i]   <= ld_d[i];
      rdy_q[i]  <= rdy_d[i];
      rd_q[i]   <= rd_d[i];
      data_q[i] <= data_d[i];
    end
  end

  // Write-back from the oldest entry; a load returning at WB is written straight through.
  assign wb_byp  = (LOAD_STAGE == WB_IDX) && ld_fill;
  assign wb_we   = v_q[WB_IDX] && rw_q[WB_IDX] && (rd_q[WB_IDX] != '0) &&
                   (rdy_q[WB_IDX] || wb_byp);
  assign wb_rd   = rd_q[WB_IDX];
  assign wb_data = wb_byp ? ld_data : data_q[WB_IDX];
  assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard cases on a DEPTH=2 instance and a
// scoreboarded random stream on a DEPTH=4 / NUM_SRC=3 / LOAD_STAGE=2 instance.
module tb_fwd_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // DEPTH=2, NUM_SRC=2, LOAD_STAGE=1 instance
  logic        a_reset, a_ex_valid, a_ex_regwrite, a_ex_is_load, a_flush, a_ld_valid;
  logic [4:0]  a_ex_rd;
  logic [31:0] a_ex_result, a_ld_data;
  logic [9:0]  a_ex_src_idx;
  logic [1:0]  a_ex_src_use;
  logic [63:0] a_rf_rdata, a_fwd_data;
  logic        a_stall, a_wb_we, a_ld_err;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data;

  fwd_scoreboard u_a (
    .clk(clk), .reset(a_reset), .ex_valid(a_ex_valid), .ex_regwrite(a_ex_regwrite),
    .ex_is_load(a_ex_is_load), .ex_rd(a_ex_rd), .ex_result(a_ex_result),
    .ex_src_idx(a_ex_src_idx), .ex_src_use(a_ex_src_use), .rf_rdata(a_rf_rdata),
    .flush(a_flush), .ld_valid(a_ld_valid), .ld_data(a_ld_data), .fwd_data(a_fwd_data),
    .stall(a_stall), .wb_we(a_wb_we), .wb_rd(a_wb_rd), .wb_data(a_wb_data), .ld_err(a_ld_err)
  );

  // DEPTH=4, NUM_SRC=3, LOAD_STAGE=2 instance
  logic        b_reset, b_ex_valid, b_ex_regwrite, b_ex_is_load, b_flush, b_ld_valid;
  logic [4:0]  b_ex_rd;
  logic [31:0] b_ex_result, b_ld_data;
  logic [14:0] b_ex_src_idx;
  logic [2:0]  b_ex_src_use;
  logic [95:0] b_rf_rdata, b_fwd_data;
  logic        b_stall, b_wb_we, b_ld_err;
  logic [4:0]  b_wb_rd;
  logic [31:0] b_wb_data;

  fwd_scoreboard #(.XLEN(32), .RFIDX_WIDTH(5), .NUM_SRC(3), .DEPTH(4), .LOAD_STAGE(2)) u_b (
    .clk(clk), .reset(b_reset), .ex_valid(b_ex_valid), .ex_regwrite(b_ex_regwrite),
    .ex_is_load(b_ex_is_load), .ex_rd(b_ex_rd), .ex_result(b_ex_result),
    .ex_src_idx(b_ex_src_idx), .ex_src_use(b_ex_src_use), .rf_rdata(b_rf_rdata),
    .flush(b_flush), .ld_valid(b_ld_valid), .ld_data(b_ld_data), .fwd_data(b_fwd_data),
    .stall(b_stall), .wb_we(b_wb_we), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .ld_err(b_ld_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] arf(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : 32'h1000 + 32'(r);
  endfunction

  task automatic a_drive(input int v, rw, ld, rd, input logic [31:0] res,
                         input int s0, s1, su, fl, ldv, input logic [31:0] ldd);
    a_ex_valid    = (v != 0);
    a_ex_regwrite = (rw != 0);
    a_ex_is_load  = (ld != 0);
    a_ex_rd       = 5'(rd);
    a_ex_result   = res;
    a_ex_src_idx  = {5'(s1), 5'(s0)};
    a_ex_src_use  = 2'(su);
    a_rf_rdata    = {arf(5'(s1)), arf(5'(s0))};
    a_flush       = (fl != 0);
    a_ld_valid    = (ldv != 0);
    a_ld_data     = ldd;
    #1;
  endtask

  task automatic a_idle();
    a_drive(0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  task automatic a_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          t;
    logic        rw;
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] data;
  } ins_t;

  typedef struct {
    int          t;
    logic [4:0]  rd;
    logic [31:0] data;
  } wbe_t;

  ins_t        hist[$];
  wbe_t        wbq[$];
  ins_t        ni;
  wbe_t        nw;
  logic [31:0] arch_rf [32];
  logic [31:0] com_rf  [32];
  int          cyc, acc;
  logic        have, cv, crw, cld, fl, ldv, lfound, es, found, exp_err, wpend;
  logic [4:0]  crd, wrd;
  logic [4:0]  cs [3];
  logic [2:0]  cu;
  logic [31:0] cres, cldd, ldd, wdat;

  initial begin
    b_reset = 1'b1; b_ex_valid = 1'b0; b_ex_regwrite = 1'b0; b_ex_is_load = 1'b0;
    b_ex_rd = '0; b_ex_result = '0; b_ex_src_idx = '0; b_ex_src_use = '0;
    b_rf_rdata = '0; b_flush = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0;

    // ---------------- reset state ----------------
    a_reset = 1'b1;
    a_drive(0, 0, 0, 0, 32'd0, 1, 2, 3, 0, 0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    a_drive(0, 0, 0, 0, 32'd0, 1, 2, 3, 0, 0, 32'd0);
    check_eq("rst_stall", 32'(a_stall), 32'd0);
    check_eq("rst_wb_we", 32'(a_wb_we), 32'd0);
    check_eq("rst_ld_err", 32'(a_ld_err), 32'd0);
    check_eq("rst_fwd0", a_fwd_data[31:0], 32'h1001);
    check_eq("rst_fwd1", a_fwd_data[63:32], 32'h1002);
    a_reset = 1'b0;

    // ---------------- back-to-back ALU forwarding ----------------
    a_drive(1, 1, 0, 1, 32'd5, 0, 0, 0, 0, 0, 32'd0);
    check_eq("b2b_stall0", 32'(a_stall), 32'd0);
    a_step();
    a_drive(1, 1, 0, 2, 32'd11, 1, 0, 1, 0, 0, 32'd0);
    check_eq("b2b_fwd_e0", a_fwd_data[31:0], 32'd5);
    check_eq("b2b_stall1", 32'(a_stall), 32'd0);
    a_step();
    a_drive(1, 0, 0, 9, 32'd0, 1, 2, 3, 0, 0, 32'd0);
    check_eq("b2b_fwd_e1", a_fwd_data[31:0], 32'd5);
    check_eq("b2b_fwd_x2", a_fwd_data[63:32], 32'd11);
    check_eq("b2b_stall2", 32'(a_stall), 32'd0);
    check_eq("b2b_wb_we", 32'(a_wb_we), 32'd1);
    check_eq("b2b_wb_rd", 32'(a_wb_rd), 32'd1);
    check_eq("b2b_wb_data", a_wb_data, 32'd5);
    a_step();
    a_idle();
    check_eq("b2b_wb2_rd", 32'(a_wb_rd), 32'd2);
    check_eq("b2b_wb2_data", a_wb_data, 32'd11);
    a_step();
    a_idle();
    check_eq("nowrite_wb_we", 32'(a_wb_we), 32'd0);
    a_step();

    // ---------------- youngest wins, x0 never matches ----------------
    a_drive(1, 1, 0, 1, 32'd7, 0, 0, 0, 0, 0, 32'd0);
    a_step();
    a_drive(1, 1, 0, 1, 32'd9, 0, 0, 0, 0, 0, 32'd0);
    a_step();
    a_drive(1, 1, 0, 0, 32'hdead, 1, 0, 1, 0, 0, 32'd0);
    check_eq("youngest", a_fwd_data[31:0], 32'd9);
    a_step();
    a_drive(1, 0, 0, 0, 32'd0, 0, 1, 3, 0, 0, 32'd0);
    check_eq("x0_rf", a_fwd_data[31:0], 32'd0);
    check_eq("x1_from_wb", a_fwd_data[63:32], 32'd9);
    check_eq("x1_wb_data", a_wb_data, 32'd9);
    a_step();
    a_idle();
    check_eq("x0_wb_we", 32'(a_wb_we), 32'd0);
    a_step();
    a_idle();
    a_step();

    // ---------------- load-use stall and bypass ----------------
    a_drive(1, 1, 1, 3, 32'hbad, 0, 0, 0, 0, 0, 32'd0);
    a_step();
    a_drive(1, 1, 0, 4, 32'h44, 3, 0, 1, 0, 0, 32'd0);
    check_eq("lu_stall", 32'(a_stall), 32'd1);
    a_step();
    a_drive(1, 1, 0, 4, 32'h44, 3, 0, 1, 0, 1, 32'h55);
    check_eq("lu_stall_rel", 32'(a_stall), 32'd0);
    check_eq("lu_bypass", a_fwd_data[31:0], 32'h55);
    check_eq("lu_wb_we", 32'(a_wb_we), 32'd1);
    check_eq("lu_wb_rd", 32'(a_wb_rd), 32'd3);
    check_eq("lu_wb_data", a_wb_data, 32'h55);
    a_step();
    a_idle();
    check_eq("lu_no_err", 32'(a_ld_err), 32'd0);
    check_eq("lu_bubble", 32'(a_wb_we), 32'd0);
    a_step();
    a_idle();
    check_eq("lu_cons_wb", a_wb_data, 32'h44);
    a_step();

    // ---------------- unused source never stalls ----------------
    a_drive(1, 1, 1, 3, 32'hbad, 0, 0, 0, 0, 0, 32'd0);
    a_step();
    a_drive(1, 1, 0, 5, 32'h77, 0, 3, 1, 0, 0, 32'd0);
    check_eq("unused_nostall", 32'(a_stall), 32'd0);
    a_step();
    a_drive(0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 1, 32'h66);
    check_eq("unused_ld_wb", a_wb_data, 32'h66);
    a_step();
    a_idle();
    check_eq("unused_cons_wb", 32'(a_wb_rd), 32'd5);
    a_step();
    a_idle();
    a_step();

    // ---------------- stray ld_valid ----------------
    a_drive(0, 0, 0, 0, 32'd0, 3, 0, 1, 0, 1, 32'h99);
    check_eq("stray_pre", 32'(a_ld_err), 32'd0);
    a_step();
    a_drive(0, 0, 0, 0, 32'd0, 3, 0, 1, 0, 0, 32'd0);
    check_eq("stray_err", 32'(a_ld_err), 32'd1);
    check_eq("stray_wb_we", 32'(a_wb_we), 32'd0);
    check_eq("stray_tbl", a_fwd_data[31:0], 32'h1003);
    a_step();
    a_idle();
    check_eq("stray_pulse1", 32'(a_ld_err), 32'd0);

    // ---------------- flush during stall, flush alone ----------------
    a_drive(1, 1, 1, 6, 32'hbad, 0, 0, 0, 0, 0, 32'd0);
    a_step();
    a_drive(1, 1, 0, 7, 32'h70, 6, 0, 1, 1, 0, 32'd0);
    check_eq("fl_stall", 32'(a_stall), 32'd1);
    a_step();
    a_drive(0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 1, 32'h60);
    check_eq("fl_ld_wb", a_wb_data, 32'h60);
    a_step();
    a_idle();
    check_eq("fl_bubble", 32'(a_wb_we), 32'd0);
    a_step();
    a_drive(1, 1, 0, 8, 32'h80, 0, 0, 0, 1, 0, 32'd0);
    a_step();
    a_idle();
    a_step();
    a_idle();
    check_eq("fl_kill", 32'(a_wb_we), 32'd0);
    a_step();

    // ---------------- reset mid-operation ----------------
    a_drive(1, 1, 1, 3, 32'hbad, 0, 0, 0, 0, 0, 32'd0);
    a_step();
    a_reset = 1'b1;
    a_idle();
    a_step();
    a_reset = 1'b0;
    a_drive(0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 1, 32'h11);
    check_eq("rstmid_wb_we", 32'(a_wb_we), 32'd0);
    a_step();
    a_idle();
    check_eq("rstmid_err", 32'(a_ld_err), 32'd1);

    // ---------------- random stream against a reference model ----------------
    for (int r = 0; r < 32; r++) begin
      arch_rf[r] = (r == 0) ? 32'd0 : $urandom;
      com_rf[r]  = arch_rf[r];
    end
    repeat (2) @(posedge clk);
    #1;
    b_reset = 1'b0;
    cyc = 0; acc = 0; have = 1'b0; exp_err = 1'b0; wpend = 1'b0;
    while ((acc < 10000 || hist.size() > 0) && cyc < 40000) begin
      while (hist.size() > 0 && (cyc - hist[0].t - 1) > 3) void'(hist.pop_front());
      if (!have) begin
        cv   = (acc < 10000) && ($urandom_range(7) != 0);
        crw  = ($urandom_range(3) != 0);
        cld  = ($urandom_range(2) == 0);
        crd  = 5'($urandom_range(7));
        cres = $urandom;
        cldd = $urandom;
        for (int k = 0; k < 3; k++) cs[k] = 5'($urandom_range(7));
        cu   = 3'($urandom_range(7));
        have = 1'b1;
      end
      fl = ($urandom_range(9) == 0);
      lfound = 1'b0;
      ldd = $urandom;
      foreach (hist[j]) begin
        if (hist[j].ld && (cyc - hist[j].t - 1) == 2) begin
          lfound = 1'b1;
          ldd    = hist[j].data;
        end
      end
      ldv = lfound || ($urandom_range(15) == 0);

      b_ex_valid = cv; b_ex_regwrite = crw; b_ex_is_load = cld; b_ex_rd = crd;
      b_ex_result = cres; b_ex_src_idx = {cs[2], cs[1], cs[0]}; b_ex_src_use = cu;
      b_rf_rdata = {com_rf[cs[2]], com_rf[cs[1]], com_rf[cs[0]]};
      b_flush = fl; b_ld_valid = ldv; b_ld_data = ldd;
      #1;

      es = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (cu[k]) begin
          found = 1'b0;
          for (int j = hist.size() - 1; j >= 0; j--) begin
            if (!found && hist[j].rw && hist[j].rd != 5'd0 && hist[j].rd == cs[k]) begin
              found = 1'b1;
              if (hist[j].ld && (cyc - hist[j].t - 1) < 2) es = 1'b1;
            end
          end
        end
      end
      es = es && cv;
      check_eq("rnd_stall", 32'(b_stall), 32'(es));
      if (cv && !es) begin
        for (int k = 0; k < 3; k++) begin
          if (cu[k]) check_eq($sformatf("rnd_fwd%0d", k), b_fwd_data[k*32 +: 32], arch_rf[cs[k]]);
        end
      end

      if (wbq.size() > 0 && wbq[0].t + 4 == cyc) begin
        check_eq("rnd_wb_we", 32'(b_wb_we), 32'd1);
        check_eq("rnd_wb_rd", 32'(b_wb_rd), 32'(wbq[0].rd));
        check_eq("rnd_wb_data", b_wb_data, wbq[0].data);
        wpend = 1'b1;
        wrd   = wbq[0].rd;
        wdat  = wbq[0].data;
        void'(wbq.pop_front());
      end else begin
        check_eq("rnd_wb_idle", 32'(b_wb_we), 32'd0);
      end

      check_eq("rnd_ld_err", 32'(b_ld_err), 32'(exp_err));
      exp_err = ldv && !lfound;

      if (cv && !es && !fl) begin
        ni.t = cyc; ni.rw = crw; ni.ld = cld; ni.rd = crd; ni.data = cld ? cldd : cres;
        hist.push_back(ni);
        if (crw && crd != 5'd0) begin
          arch_rf[crd] = ni.data;
          nw.t = cyc; nw.rd = crd; nw.data = ni.data;
          wbq.push_back(nw);
        end
        acc++;
        have = 1'b0;
      end else if (!(cv && es) || fl) begin
        have = 1'b0;
      end

      @(posedge clk);
      #1;
      cyc++;
      if (wpend) com_rf[wrd] = wdat;
      wpend = 1'b0;
    end
    check_eq("rnd_completed", 32'(acc >= 10000), 32'd1);
    check_eq("rnd_wbq_empty", 32'(wbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
